// File: rtl/psum_deskew_accum_if.sv
// Bundles the psum_deskew_accum data, configuration and result handshake signals.
// master = upstream/sink side that drives inputs; slave = the deskew/accumulate block.
interface psum_deskew_accum_if #(
  parameter int COLS  = 32,
  parameter int ACC_W = 24
);
  logic [$clog2(COLS)-1:0] last_col;
  logic [7:0]              num_tiles;
  logic [COLS*ACC_W-1:0]   threshold;
  logic [COLS*16-1:0]      partialsum_in;
  logic [COLS-1:0]         partialsum_in_valid;
  logic [COLS*ACC_W-1:0]   result_out;
  logic [COLS-1:0]         result_bits;
  logic                    result_valid;
  logic                    result_ready;
  logic                    busy;
  logic                    overflow;

  modport master (
    output last_col, num_tiles, threshold, partialsum_in, partialsum_in_valid, result_ready,
    input  result_out, result_bits, result_valid, busy, overflow
  );

  modport slave (
    input  last_col, num_tiles, threshold, partialsum_in, partialsum_in_valid, result_ready,
    output result_out, result_bits, result_valid, busy, overflow
  );
endinterface

// File: rtl/psum_deskew_accum.sv
// Deskews per-column systolic partial sums through column FIFOs and accumulates num_tiles vectors.
// Result valid 2 cycles after the last enabled column write; pending result stalls pops, FIFOs absorb the stall.
module psum_deskew_accum #(
  parameter int COLS  = 32,
  parameter int DEPTH = 32,
  parameter int ACC_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  psum_deskew_accum_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  localparam int XW = ACC_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [15:0]              r_mem  [COLS][DEPTH];
  logic [PW-1:0]            r_wptr [COLS];
  logic [PW-1:0]            r_rptr [COLS];
  logic [NW-1:0]            r_cnt  [COLS];
  logic signed [ACC_W-1:0]  r_acc  [COLS];
  logic [7:0]               r_tile_cnt;
  logic [COLS*ACC_W-1:0]    r_result;
  logic [COLS-1:0]          r_bits;
  logic                     r_valid;
  logic                     r_ovf;

  logic [COLS-1:0]          w_en;
  logic [COLS-1:0]          w_full;
  logic [COLS-1:0]          w_nonempty;
  logic [COLS-1:0]          w_push;
  logic [COLS-1:0]          w_popj;
  logic [COLS-1:0]          w_ge;
  logic signed [15:0]       w_head [COLS];
  logic signed [XW-1:0]     w_wide [COLS];
  logic signed [ACC_W-1:0]  w_sum  [COLS];
  logic                     w_aligned;
  logic                     w_pop;
  logic                     w_last;
  logic                     w_ovf_hit;
  logic [7:0]               w_tiles_m1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_aligned = 1'b1;
    for (int j = 0; j < COLS; j++) begin
      w_en[j]       = (j <= int'(bus.last_col));
      w_full[j]     = (r_cnt[j] == NW'(DEPTH));
      w_nonempty[j] = (r_cnt[j] != '0);
      w_push[j]     = w_en[j] & bus.partialsum_in_valid[j] & ~w_full[j];
      w_head[j]     = r_mem[j][r_rptr[j]];
      w_wide[j]     = XW'(r_acc[j]) + XW'(w_head[j]);
      // Sign disagreement between the guard bit and the MSB means the add left the ACC_W range.
      if (w_wide[j][ACC_W] != w_wide[j][ACC_W-1]) begin
        w_sum[j] = w_wide[j][ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
        w_sum[j] = w_wide[j][ACC_W-1:0];
      end
      w_ge[j] = (w_sum[j] >= $signed(bus.threshold[j*ACC_W +: ACC_W]));
      if (w_en[j] && !w_nonempty[j]) begin
        w_aligned = 1'b0;
      end
    end
    w_pop      = w_aligned & ~(r_valid & ~bus.result_ready);
    w_popj     = {COLS{w_pop}} & w_en;
    w_tiles_m1 = (bus.num_tiles == 8'd0) ? 8'd0 : bus.num_tiles - 8'd1;
    w_last     = (r_tile_cnt == w_tiles_m1);
    w_ovf_hit  = |(w_en & bus.partialsum_in_valid & w_full);
  end

  // FIFO storage carries no reset; the counts and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int j = 0; j < COLS; j++) begin
      if (w_push[j]) begin
        r_mem[j][r_wptr[j]] <= bus.partialsum_in[j*16 +: 16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < COLS; j++) begin
        r_wptr[j] <= '0;
        r_rptr[j] <= '0;
        r_cnt[j]  <= '0;
        r_acc[j]  <= '0;
      end
      r_tile_cnt <= '0;
      r_result   <= '0;
      r_bits     <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      for (int j = 0; j < COLS; j++) begin
        if (w_push[j]) begin
          r_wptr[j] <= ptr_inc(r_wptr[j]);
        end
        if (w_popj[j]) begin
          r_rptr[j] <= ptr_inc(r_rptr[j]);
        end
        case ({w_push[j], w_popj[j]})
          2'b10:   r_cnt[j] <= r_cnt[j] + 1'b1;
          2'b01:   r_cnt[j] <= r_cnt[j] - 1'b1;
          default: r_cnt[j] <= r_cnt[j];
        endcase
      end

      if (w_ovf_hit) begin
        r_ovf <= 1'b1;
      end

      if (w_pop) begin
        if (w_last) begin
          r_tile_cnt <= '0;
          for (int j = 0; j < COLS; j++) begin
            r_acc[j]                  <= '0;
            r_result[j*ACC_W +: ACC_W] <= w_en[j] ? w_sum[j] : '0;
            r_bits[j]                 <= w_en[j] & w_ge[j];
          end
        end else begin
          r_tile_cnt <= r_tile_cnt + 8'd1;
          for (int j = 0; j < COLS; j++) begin
            r_acc[j] <= w_en[j] ? w_sum[j] : '0;
          end
        end
      end

      // A last-tile pop in the same cycle as an accept reloads valid for back-to-back results.
      if (w_pop && w_last) begin
        r_valid <= 1'b1;
      end else if (bus.result_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.result_out   = r_result;
  assign bus.result_bits  = r_bits;
  assign bus.result_valid = r_valid;
  assign bus.overflow     = r_ovf;
  assign bus.busy         = (|w_nonempty) | (r_tile_cnt != 8'd0) | r_valid;

endmodule

// File: tb/tb_psum_deskew_accum.sv
// Randomized and directed bench for psum_deskew_accum against a queue-based reference model.
module tb_psum_deskew_accum;
  localparam int COLS  = 32;
  localparam int DEPTH = 32;
  localparam int ACC_W = 18;
  localparam int CW    = $clog2(COLS);
  localparam int W     = COLS * ACC_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  psum_deskew_accum_if #(.COLS(COLS), .ACC_W(ACC_W)) bus ();

  psum_deskew_accum #(.COLS(COLS), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model state: one queue per column, plain integer sums.
  logic signed [15:0] mq [COLS][$];
  longint             macc [COLS];
  longint             mres [COLS];
  logic [COLS-1:0]    mbits;
  int                 mtile;
  bit                 mvalid;
  bit                 movf;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    longint mx, mn;
    mx = (longint'(1) <<< (ACC_W - 1)) - 1;
    mn = -(longint'(1) <<< (ACC_W - 1));
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  function automatic longint thr_of(input int j);
    return longint'($signed(bus.threshold[j*ACC_W +: ACC_W]));
  endfunction

  function automatic logic [W-1:0] pack_res();
    logic [W-1:0] v;
    v = '0;
    for (int j = 0; j < COLS; j++) v[j*ACC_W +: ACC_W] = ACC_W'(mres[j]);
    return v;
  endfunction

  function automatic logic [W-1:0] mk_vec(input int a, input int b, input int c, input int d);
    logic [W-1:0] v;
    v = '0;
    v[0 +: ACC_W]       = ACC_W'(a);
    v[ACC_W +: ACC_W]   = ACC_W'(b);
    v[2*ACC_W +: ACC_W] = ACC_W'(c);
    v[3*ACC_W +: ACC_W] = ACC_W'(d);
    return v;
  endfunction

  function automatic bit model_busy();
    bit b;
    b = mvalid || (mtile != 0);
    for (int j = 0; j < COLS; j++) if (mq[j].size() != 0) b = 1'b1;
    return b;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int lc, lim;
    bit aligned, pop;
    bit [COLS-1:0] full;
    longint s;
    if (!rst_n) begin
      for (int j = 0; j < COLS; j++) begin
        mq[j].delete();
        macc[j] = 0;
        mres[j] = 0;
      end
      mbits = '0; mtile = 0; mvalid = 0; movf = 0;
      return;
    end
    lc  = int'(bus.last_col);
    lim = (bus.num_tiles == 8'd0) ? 1 : int'(bus.num_tiles);
    aligned = 1'b1;
    for (int j = 0; j < COLS; j++) begin
      full[j] = (mq[j].size() >= DEPTH);
      if (j <= lc && mq[j].size() == 0) aligned = 1'b0;
    end
    pop = aligned && !(mvalid && !bus.result_ready);
    if (bus.result_ready) mvalid = 1'b0;
    if (pop) begin
      for (int j = 0; j <= lc; j++) begin
        s = longint'(mq[j].pop_front());
        macc[j] = sat(macc[j] + s);
      end
      mtile++;
      if (mtile == lim) begin
        for (int j = 0; j < COLS; j++) begin
          mres[j]  = (j <= lc) ? macc[j] : 0;
          mbits[j] = (j <= lc) && (macc[j] >= thr_of(j));
          macc[j]  = 0;
        end
        mtile  = 0;
        mvalid = 1'b1;
      end
    end
    for (int j = 0; j <= lc; j++) begin
      if (bus.partialsum_in_valid[j]) begin
        if (full[j]) movf = 1'b1;
        else mq[j].push_back($signed(bus.partialsum_in[j*16 +: 16]));
      end
    end
  endtask

  task automatic compare_all();
    chk("valid", W'(bus.result_valid), W'(mvalid));
    chk("busy", W'(bus.busy), W'(model_busy()));
    chk("overflow", W'(bus.overflow), W'(movf));
    chk("result_out", bus.result_out, pack_res());
    chk("result_bits", W'(bus.result_bits), W'(mbits));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_thr(input int t);
    for (int j = 0; j < COLS; j++) bus.threshold[j*ACC_W +: ACC_W] = ACC_W'(t);
  endtask

  task automatic drive(input int col, input int val);
    bus.partialsum_in_valid[col] = 1'b1;
    bus.partialsum_in[col*16 +: 16] = 16'(val);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.partialsum_in_valid = '0;
    bus.result_ready = 1'b1;
    while (model_busy() && n < 300) begin
      tick();
      n++;
    end
    chk("drain_timeout", W'(model_busy()), W'(0));
  endtask

  task automatic do_reset();
    bus.partialsum_in_valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  int pulses;
  int k;
  int t4v [3][4];
  int lc, nt, lim, nv;
  int sent [COLS];
  bit done;

  initial begin
    bus.last_col = '0;
    bus.num_tiles = 8'd1;
    bus.threshold = '0;
    bus.partialsum_in = '0;
    bus.partialsum_in_valid = '0;
    bus.result_ready = 1'b1;
    do_reset();
    tick();

    // Reset mid-stream with data parked in FIFOs.
    bus.last_col = CW'(3);
    bus.num_tiles = 8'd1;
    set_thr(0);
    drive(0, 11); drive(1, 12);
    tick(); tick();
    bus.partialsum_in_valid = '0;
    chk("pre_reset_busy", W'(bus.busy), W'(1));
    do_reset();
    chk("rst_valid", W'(bus.result_valid), W'(0));
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_ovf", W'(bus.overflow), W'(0));
    chk("rst_result", bus.result_out, '0);
    drive(0, 10); drive(1, 20); drive(2, 30); drive(3, -40);
    tick();
    bus.partialsum_in_valid = '0;
    tick();
    chk("post_rst_valid", W'(bus.result_valid), W'(1));
    chk("post_rst_sum", bus.result_out, mk_vec(10, 20, 30, -40));
    drain();

    // Skew alignment: column j arrives j cycles after column 0.
    set_thr(2);
    for (int c = 0; c < 4; c++) begin
      bus.partialsum_in_valid = '0;
      drive(c, c + 1);
      tick();
    end
    bus.partialsum_in_valid = '0;
    chk("skew_not_yet", W'(bus.result_valid), W'(0));
    tick();
    chk("skew_valid", W'(bus.result_valid), W'(1));
    chk("skew_result", bus.result_out, mk_vec(1, 2, 3, 4));
    chk("skew_bits", W'(bus.result_bits), W'(32'h0000_000E));
    drain();

    // Accumulate three tiles on one column at two thresholds.
    bus.last_col = CW'(0);
    bus.num_tiles = 8'd3;
    for (int p = 0; p < 2; p++) begin
      set_thr(57 + p);
      drive(0, 100); tick();
      drive(0, -50); tick();
      drive(0, 7);   tick();
      bus.partialsum_in_valid = '0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (bus.result_valid) begin
          pulses++;
          chk("acc_sum", bus.result_out, mk_vec(57, 0, 0, 0));
          chk("acc_bit", W'(bus.result_bits[0]), W'(p == 0));
        end
      end
      chk("acc_pulses", W'(pulses), W'(1));
      drain();
    end

    // Backpressure: three skewed vectors while the sink stalls.
    bus.last_col = CW'(3);
    bus.num_tiles = 8'd1;
    set_thr(0);
    for (int v = 0; v < 3; v++)
      for (int j = 0; j < 4; j++) t4v[v][j] = int'($urandom_range(0, 60000)) - 30000;
    bus.result_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      bus.partialsum_in_valid = '0;
      for (int j = 0; j < 4; j++)
        if (t - j >= 0 && t - j < 3) drive(j, t4v[t-j][j]);
      tick();
    end
    bus.partialsum_in_valid = '0;
    bus.result_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.result_valid && k < 3) begin
        chk("bp_order", bus.result_out, mk_vec(t4v[k][0], t4v[k][1], t4v[k][2], t4v[k][3]));
        k++;
      end
      tick();
    end
    chk("bp_count", W'(k), W'(3));
    chk("bp_ovf", W'(bus.overflow), W'(0));
    drain();

    // Overflow: only column 0 of 32 enabled columns ever writes.
    do_reset();
    bus.last_col = CW'(COLS - 1);
    bus.result_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.partialsum_in_valid = '0;
      drive(0, int'($urandom_range(0, 65535)));
      tick();
    end
    bus.partialsum_in_valid = '0;
    chk("ovf_set", W'(bus.overflow), W'(1));
    chk("ovf_busy", W'(bus.busy), W'(1));
    tick(); tick(); tick();
    chk("ovf_sticky", W'(bus.overflow), W'(1));
    do_reset();
    chk("ovf_cleared", W'(bus.overflow), W'(0));
    bus.result_ready = 1'b1;

    // Saturation at both ends of the 18-bit range.
    bus.last_col = CW'(0);
    bus.num_tiles = 8'd5;
    set_thr(0);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 5; i++) begin
        drive(0, (p == 0) ? 32767 : -32768);
        tick();
      end
      bus.partialsum_in_valid = '0;
      tick();
      chk("sat_valid", W'(bus.result_valid), W'(1));
      chk("sat_value", bus.result_out, mk_vec((p == 0) ? 131071 : -131072, 0, 0, 0));
      drain();
    end

    // Random configurations with jittered per-column arrival.
    for (int r = 0; r < 10; r++) begin
      drain();
      lc  = int'($urandom_range(0, COLS - 1));
      nt  = int'($urandom_range(0, 6));
      lim = (nt == 0) ? 1 : nt;
      nv  = lim * 3;
      bus.last_col  = CW'(lc);
      bus.num_tiles = 8'(nt);
      for (int j = 0; j < COLS; j++) begin
        bus.threshold[j*ACC_W +: ACC_W] = ACC_W'(int'($urandom_range(0, 131071)) - 65536);
        sent[j] = 0;
      end
      for (int t = 0; t < 600; t++) begin
        done = 1'b1;
        for (int j = 0; j <= lc; j++) if (sent[j] < nv) done = 1'b0;
        if (done) break;
        bus.result_ready = ($urandom_range(0, 3) != 0);
        bus.partialsum_in = '0;
        for (int j = 0; j < COLS; j++) begin
          bus.partialsum_in[j*16 +: 16] = 16'($urandom);
          if (j > lc) begin
            bus.partialsum_in_valid[j] = 1'($urandom);
          end else if (sent[j] < nv && mq[j].size() < DEPTH - 2 && $urandom_range(0, 1) == 1) begin
            bus.partialsum_in_valid[j] = 1'b1;
            sent[j]++;
          end else begin
            bus.partialsum_in_valid[j] = 1'b0;
          end
        end
        tick();
      end
      bus.partialsum_in_valid = '0;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
